// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the 16-bit MIPS fetch stage.
//
// Holds the fetch address and selects the next one: sequential, PC-relative
// branch, absolute jump, call (jump + push link) or return (pop link). An
// internal return-address stack (RAS) provides the link values for returns.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   stall       1 = hold PC, RAS contents and RAS count this cycle
//   pc_sel      000 seq, 001 branch, 010 jump, 011 call, 100 return, else seq
//   branch_off  signed branch offset in instructions
//   target      absolute jump/call target (low INC_LOG2 bits ignored)
//   err_clr     clears the sticky ras_err flag on the edge
//   pc_out      registered current PC
//   pc_plus     pc_out + 2^INC_LOG2, combinational
//   ras_full    RAS holds DEPTH entries
//   ras_empty   RAS holds no entries
//   ras_err     sticky RAS overflow/underflow flag
module pc_unit #(
    parameter int unsigned           WIDTH     = 16,
    parameter int unsigned           INC_LOG2  = 1,
    parameter logic [WIDTH-1:0]      RESET_VEC = '0,
    parameter int unsigned           DEPTH     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       pc_sel,
    input  logic [WIDTH-1:0] branch_off,
    input  logic [WIDTH-1:0] target,
    input  logic             err_clr,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WIDTH-1:0] INC        = WIDTH'(1) << INC_LOG2;
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(INC - WIDTH'(1));
    localparam logic [CW-1:0]    FULL_CNT   = CW'(DEPTH);

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'b000,
        SEL_BRANCH = 3'b001,
        SEL_JUMP   = 3'b010,
        SEL_CALL   = 3'b011,
        SEL_RET    = 3'b100
    } pc_sel_e;

    // Force an address onto an instruction boundary.
    function automatic logic [WIDTH-1:0] align_addr(input logic [WIDTH-1:0] a);
        return a & ALIGN_MASK;
    endfunction

    // Scale a signed instruction offset to bytes; truncation to WIDTH gives
    // the same bits as sign-extend-then-shift under modulo arithmetic.
    function automatic logic signed [WIDTH-1:0] scale_off(input logic signed [WIDTH-1:0] o);
        return o <<< INC_LOG2;
    endfunction

    logic [WIDTH-1:0] ras [DEPTH];
    logic [CW-1:0]    count;

    logic [WIDTH-1:0]        pc_nxt;
    logic                    push;
    logic                    pop;
    logic                    err_set;
    logic signed [WIDTH-1:0] off_bytes;
    logic [IW-1:0]           push_idx;
    logic [IW-1:0]           top_idx;

    assign pc_plus   = pc_out + INC;
    assign ras_full  = (count == FULL_CNT);
    assign ras_empty = (count == '0);
    assign off_bytes = scale_off(branch_off);
    assign push_idx  = IW'(count);
    assign top_idx   = IW'(count - CW'(1));

    // Next-PC and RAS request decode
    always_comb begin
        pc_nxt  = pc_plus;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (!stall) begin
            case (pc_sel)
                SEL_BRANCH: pc_nxt = pc_plus + off_bytes;
                SEL_JUMP:   pc_nxt = align_addr(target);
                SEL_CALL: begin
                    // Jump is taken even when the link cannot be saved.
                    pc_nxt = align_addr(target);
                    if (ras_full) err_set = 1'b1;
                    else          push    = 1'b1;
                end
                SEL_RET: begin
                    // Underflow falls through to sequential fetch.
                    if (ras_empty) begin
                        err_set = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        pc_nxt = ras[top_idx];
                    end
                end
                default: pc_nxt = pc_plus;
            endcase
        end
    end

    // State update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out  <= RESET_VEC;
            count   <= '0;
            ras_err <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) ras[i] <= '0;
        end else begin
            if (!stall) pc_out <= pc_nxt;
            if (push) begin
                ras[push_idx] <= pc_plus;
                count         <= count + CW'(1);
            end else if (pop) begin
                count <= count - CW'(1);
            end
            // A fresh error on the same edge beats the clear.
            if (err_set)      ras_err <= 1'b1;
            else if (err_clr) ras_err <= 1'b0;
        end
    end

endmodule
